// File: rtl/lcm_pkg.sv
// rtl/lcm_pkg.sv - shared widths, state encoding and counter sizing for the LCM block
package lcm_pkg;

  // Operand width matching the upstream HCF engine, and the derived product width
  localparam int LCM_W  = 4;
  localparam int LCM_PW = 2 * LCM_W;

  // Counter width able to hold an iteration index for a PW-bit datapath
  function automatic int cnt_width(input int pw);
    return $clog2(pw) + 1;
  endfunction

  localparam int LCM_CW = cnt_width(LCM_PW);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/shift_sub_div.sv
// rtl/shift_sub_div.sv - PW-bit restoring shift-subtract divider with start/done handshake
module shift_sub_div
  import lcm_pkg::*;
#(
  parameter int PW = LCM_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] dividend,
  input  logic [PW-1:0] divisor,
  output logic [PW-1:0] quotient,
  output logic          done
);

  localparam int CW = cnt_width(PW);

  logic [PW-1:0] rem;
  logic [PW-1:0] q;
  logic [CW-1:0] cnt;
  logic          running;

  logic [PW-1:0] rem_src;
  logic [PW-1:0] q_src;
  logic [PW:0]   shifted;
  logic          ge;
  logic [PW-1:0] rem_next;
  logic [PW-1:0] q_next;

  // One restoring step; the start cycle runs the first step straight off the new dividend
  always_comb begin
    rem_src  = start ? '0 : rem;
    q_src    = start ? dividend : q;
    shifted  = {rem_src, q_src[PW-1]};
    ge       = (shifted >= {1'b0, divisor});
    // When ge holds the true difference is below divisor, so the low PW bits are exact
    rem_next = ge ? (shifted[PW-1:0] - divisor) : shifted[PW-1:0];
    q_next   = {q_src[PW-2:0], ge};
  end

  // Iterate PW steps; done pulses for one cycle as the last quotient bit lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= rem_next;
        q       <= q_next;
        cnt     <= CW'(1);
        running <= 1'b1;
      end else if (running) begin
        rem <= rem_next;
        q   <= q_next;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(PW - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = q;

endmodule

// File: rtl/lcm_calc.sv
// rtl/lcm_calc.sv - LCM = (A*B)/HCF via shift-add multiply then restoring divide
module lcm_calc
  import lcm_pkg::*;
#(
  parameter  int W  = LCM_W,
  localparam int PW = 2 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic [W-1:0]  hcf_in,
  input  logic          hcf_done,
  output logic [PW-1:0] lcm,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int CW = cnt_width(PW);

  state_t        state;
  logic          hcf_done_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  mplier;
  logic [W-1:0]  hcf_q;
  logic [PW-1:0] product;
  logic [CW-1:0] cnt;
  logic          div_start;
  logic          div_done;
  logic [PW-1:0] div_quot;
  logic          start;

  // hcf_done is a level, so only its rising edge counts as a new request
  assign start = hcf_done & ~hcf_done_q;

  // Control FSM with the inline multiplier; all outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hcf_done_q <= 1'b0;
      a_q        <= '0;
      mplier     <= '0;
      hcf_q      <= '0;
      product    <= '0;
      cnt        <= '0;
      div_start  <= 1'b0;
      lcm        <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      hcf_done_q <= hcf_done;
      div_start  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a_in;
            mplier <= b_in;
            hcf_q  <= hcf_in;
            done   <= 1'b0;
            err    <= 1'b0;
            if (hcf_in == '0) begin
              // A=B=0 upstream: nothing to divide by, flag it straight away
              state <= DONE;
              lcm   <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state   <= MUL;
              busy    <= 1'b1;
              cnt     <= '0;
              product <= '0;
            end
          end
        end
        MUL: begin
          if (mplier[0]) begin
            product <= product + ({{W{1'b0}}, a_q} << cnt);
          end
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state     <= DIV;
            cnt       <= '0;
            div_start <= 1'b1;
          end
        end
        DIV: begin
          if (div_done) begin
            lcm   <= div_quot;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  shift_sub_div #(
    .PW(PW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (product),
    .divisor  ({{W{1'b0}}, hcf_q}),
    .quotient (div_quot),
    .done     (div_done)
  );

endmodule

// File: tb/tb_lcm_calc.sv
// tb/tb_lcm_calc.sv - self-checking bench for lcm_calc against an arithmetic reference
module tb_lcm_calc;

  localparam int W   = 4;
  localparam int PW  = 2 * W;
  localparam int LAT = 3 * W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic [W-1:0]  hcf_in = '0;
  logic          hcf_done = 1'b0;
  logic [PW-1:0] lcm;
  logic          done;
  logic          busy;
  logic          err;

  int tests = 0;
  int fails = 0;

  lcm_calc #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .hcf_in   (hcf_in),
    .hcf_done (hcf_done),
    .lcm      (lcm),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int gcd(input int x, input int y);
    int a;
    int b;
    int t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference: floor(A*B/H), or 0 with err when H is zero
  function automatic int ref_lcm(input int a, input int b, input int h);
    if (h == 0) return 0;
    return (a * b) / h;
  endfunction

  // Raise hcf_done with an operand set and check the result and its latency
  task automatic run_op(input int a, input int b, input int h, input string tag);
    int n;
    int exp_lat;
    exp_lat = (h == 0) ? 0 : LAT;
    a_in = W'(a);
    b_in = W'(b);
    hcf_in = W'(h);
    hcf_done = 1'b1;
    tick;
    // Operands must have been captured at the start edge only
    a_in = W'($urandom);
    b_in = W'($urandom);
    hcf_in = W'($urandom);
    n = 0;
    while (!done && n < 20) begin
      check($sformatf("%s busy_n%0d", tag, n), busy, 1);
      tick;
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " done"}, done, 1);
    check({tag, " busy_off"}, busy, 0);
    check({tag, " err"}, err, (h == 0) ? 1 : 0);
    check({tag, " lcm"}, lcm, ref_lcm(a, b, h));
  endtask

  task automatic release_start;
    hcf_done = 1'b0;
    tick;
  endtask

  initial begin
    int a;
    int b;
    int h;
    int n;

    // Reset state, visible without any clock edge
    #1;
    check("rst lcm", lcm, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("idle done", done, 0);

    // Directed cases from the plan
    run_op(12, 8, 4, "normal");
    release_start;
    run_op(15, 14, 1, "max");
    release_start;
    run_op(0, 6, 6, "zero_a");
    release_start;
    run_op(0, 0, 0, "zero_all");
    release_start;
    run_op(7, 5, 3, "floor");
    release_start;

    // Second rising edge while busy must be ignored
    a_in = 4'd9;
    b_in = 4'd6;
    hcf_in = 4'd3;
    hcf_done = 1'b1;
    tick;
    n = 0;
    repeat (4) begin
      tick;
      n++;
    end
    hcf_done = 1'b0;
    tick;
    n++;
    a_in = 4'd10;
    b_in = 4'd4;
    hcf_in = 4'd2;
    hcf_done = 1'b1;
    while (!done && n < 20) begin
      tick;
      n++;
    end
    check("busy_start latency", n, LAT);
    check("busy_start lcm", lcm, 18);
    repeat (3) tick;
    check("busy_start no_restart done", done, 1);
    check("busy_start no_restart busy", busy, 0);
    check("busy_start hold lcm", lcm, 18);
    release_start;
    run_op(10, 4, 2, "after_busy");
    release_start;

    // Level held high: one computation only
    run_op(5, 3, 1, "level");
    repeat (40) begin
      tick;
      check("level done", done, 1);
      check("level busy", busy, 0);
      check("level lcm", lcm, 15);
    end
    release_start;

    // Asynchronous reset mid-divide
    run_op(7, 3, 1, "pre_rst");
    release_start;
    a_in = 4'd11;
    b_in = 4'd13;
    hcf_in = 4'd1;
    hcf_done = 1'b1;
    tick;
    repeat (8) tick;
    check("mid busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst lcm", lcm, 0);
    check("arst done", done, 0);
    check("arst busy", busy, 0);
    check("arst err", err, 0);
    hcf_done = 1'b0;
    #2;
    rst = 1'b0;
    tick;
    tick;
    check("post_rst done", done, 0);
    check("post_rst busy", busy, 0);
    run_op(11, 13, 1, "post_rst");
    release_start;

    // Randomized operand sets, back-to-back starts from DONE
    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: h = int'($urandom_range(0, 15));
        1: h = 0;
        default: h = gcd(a, b);
      endcase
      run_op(a, b, h, $sformatf("rnd%0d", i));
      release_start;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
